// File: rtl/rp_pio_err_ctrl.sv
// Root Port PIO error controller: tag allocation, per-tag completion timeout,
// RP PIO status classification, mask, RW1C status and first-error pointer.
module rp_pio_err_ctrl #(
   parameter int NUM_TAGS   = 8,
   parameter int CTO_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid_i,
   input  logic [1:0]                    req_type_i,
   output logic                          req_ready_o,
   output logic [$clog2(NUM_TAGS)-1:0]   req_tag_o,
   input  logic                          cpl_valid_i,
   input  logic [$clog2(NUM_TAGS)-1:0]   cpl_tag_i,
   input  logic [2:0]                    cpl_status_i,
   input  logic [31:0]                   mask_i,
   input  logic                          sts_w1c_i,
   input  logic [31:0]                   sts_wdata_i,
   output logic [31:0]                   status_o,
   output logic                          first_err_vld_o,
   output logic [4:0]                    first_err_ptr_o,
   output logic [$clog2(NUM_TAGS)-1:0]   first_err_tag_o,
   output logic                          err_irq_o,
   output logic                          unexp_cpl_o,
   output logic [$clog2(NUM_TAGS):0]     outstanding_o
);

   localparam int TW = $clog2(NUM_TAGS);
   localparam int CW = $clog2(CTO_CYCLES);
   // Loaded with CTO_CYCLES-1 so that the tag expires in cycle T+CTO_CYCLES.
   localparam logic [CW-1:0] CNT_LOAD = CW'(CTO_CYCLES - 1);

   function automatic logic [4:0] grp_base(input logic [1:0] t);
      case (t)
         2'd0:    grp_base = 5'd0;
         2'd1:    grp_base = 5'd8;
         default: grp_base = 5'd16;
      endcase
   endfunction

   logic [NUM_TAGS-1:0] busy_q, busy_d;
   logic [1:0]          type_q [NUM_TAGS];
   logic [1:0]          type_d [NUM_TAGS];
   logic [CW-1:0]       cnt_q  [NUM_TAGS];
   logic [CW-1:0]       cnt_d  [NUM_TAGS];
   logic [31:0]         status_q, status_d;
   logic                vld_q, vld_d;
   logic [4:0]          ptr_q, ptr_d;
   logic [TW-1:0]       ptag_q, ptag_d;
   logic                irq_q, irq_d;
   logic                unexp_q, unexp_d;
   logic [TW:0]         outst_q, outst_d;

   logic                req_ready_s;
   logic [TW-1:0]       req_tag_s;
   logic                alloc_s;
   logic                cpl_hit_s;
   logic                cpl_err_s;
   logic [4:0]          cpl_idx_s;
   logic [NUM_TAGS-1:0] expire_s;
   logic [NUM_TAGS-1:0] cto_s;
   logic [31:0]         new_ev_s;
   logic [TW-1:0]       ev_tag_s [32];
   logic [31:0]         clr_s;
   logic [31:0]         unm_s;
   logic [4:0]          cap_ptr_s;

   // Lowest free tag from the registered busy vector.
   always_comb begin
      req_ready_s = ~&busy_q;
      req_tag_s   = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         req_tag_s = busy_q[i] ? req_tag_s : TW'(i);
      end
   end

   // Per-tag timers, completion handling, allocation and event generation.
   always_comb begin
      logic [4:0] idx;
      busy_d   = busy_q;
      type_d   = type_q;
      cnt_d    = cnt_q;
      new_ev_s = 32'h0000_0000;
      idx      = 5'd0;
      for (int b = 0; b < 32; b++) begin
         ev_tag_s[b] = '0;
      end
      cpl_hit_s = cpl_valid_i && busy_q[cpl_tag_i];
      cpl_err_s = cpl_hit_s && (cpl_status_i != 3'b000);
      cpl_idx_s = grp_base(type_q[cpl_tag_i]) + ((cpl_status_i == 3'b100) ? 5'd1 : 5'd0);
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         expire_s[i]   = busy_q[i] && (cnt_q[i] == '0);
         cto_s[i]      = expire_s[i] && !(cpl_hit_s && (cpl_tag_i == TW'(i)));
         busy_d[i]     = busy_q[i] & ~expire_s[i];
         cnt_d[i]      = (busy_q[i] && !expire_s[i]) ? (cnt_q[i] - CW'(1)) : cnt_q[i];
         idx           = grp_base(type_q[i]) + 5'd2;
         new_ev_s[idx] = new_ev_s[idx] | cto_s[i];
         ev_tag_s[idx] = cto_s[i] ? TW'(i) : ev_tag_s[idx];
      end
      busy_d[cpl_tag_i]   = busy_d[cpl_tag_i] & ~cpl_hit_s;
      new_ev_s[cpl_idx_s] = new_ev_s[cpl_idx_s] | cpl_err_s;
      ev_tag_s[cpl_idx_s] = cpl_err_s ? cpl_tag_i : ev_tag_s[cpl_idx_s];

      alloc_s           = req_valid_i && req_ready_s;
      busy_d[req_tag_s] = busy_d[req_tag_s] | alloc_s;
      type_d[req_tag_s] = alloc_s ? req_type_i : type_d[req_tag_s];
      cnt_d[req_tag_s]  = alloc_s ? CNT_LOAD : cnt_d[req_tag_s];

      outst_d = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         outst_d = outst_d + {{TW{1'b0}}, busy_d[i]};
      end
   end

   // Status RW1C (set wins over clear), pointer capture/invalidate, pulses.
   always_comb begin
      clr_s     = sts_w1c_i ? sts_wdata_i : 32'h0000_0000;
      unm_s     = new_ev_s & ~mask_i;
      cap_ptr_s = 5'd0;
      for (int b = 31; b >= 0; b--) begin
         cap_ptr_s = unm_s[b] ? 5'(b) : cap_ptr_s;
      end
      status_d = (status_q & ~clr_s) | new_ev_s;
      irq_d    = |unm_s;
      unexp_d  = cpl_valid_i && !busy_q[cpl_tag_i];
      ptr_d    = ptr_q;
      ptag_d   = ptag_q;
      if (!vld_q) begin
         if (|unm_s) begin
            vld_d  = 1'b1;
            ptr_d  = cap_ptr_s;
            ptag_d = ev_tag_s[cap_ptr_s];
         end else begin
            vld_d  = 1'b0;
         end
      end else if (clr_s[ptr_q] && !new_ev_s[ptr_q]) begin
         vld_d = 1'b0;
      end else begin
         vld_d = 1'b1;
      end
   end

   // State registers; reset drops every outstanding tag silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         status_q <= 32'h0000_0000;
         vld_q    <= 1'b0;
         ptr_q    <= 5'd0;
         ptag_q   <= '0;
         irq_q    <= 1'b0;
         unexp_q  <= 1'b0;
         outst_q  <= '0;
         for (int i = 0; i < NUM_TAGS; i++) begin
            type_q[i] <= 2'd0;
            cnt_q[i]  <= '0;
         end
      end else begin
         busy_q   <= busy_d;
         status_q <= status_d;
         vld_q    <= vld_d;
         ptr_q    <= ptr_d;
         ptag_q   <= ptag_d;
         irq_q    <= irq_d;
         unexp_q  <= unexp_d;
         outst_q  <= outst_d;
         for (int i = 0; i < NUM_TAGS; i++) begin
            type_q[i] <= type_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   assign req_ready_o     = req_ready_s;
   assign req_tag_o       = req_tag_s;
   assign status_o        = status_q;
   assign first_err_vld_o = vld_q;
   assign first_err_ptr_o = ptr_q;
   assign first_err_tag_o = ptag_q;
   assign err_irq_o       = irq_q;
   assign unexp_cpl_o     = unexp_q;
   assign outstanding_o   = outst_q;

endmodule
